// File: rtl/sobel_window_ctrl_if.sv
// Control bus between the Sobel frame sequencer and its pixel source / line-buffer datapath.
// The timeout signal exists only when SOBEL_CTRL_TIMEOUT_EN is defined.
interface sobel_window_ctrl_if #(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32
);
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic          start;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          fifo_enable_c;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          window_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          frame_done;
`ifdef SOBEL_CTRL_TIMEOUT_EN
  logic          timeout;
`endif

  modport master (
    output start, pixel_valid,
    input  pixel_ready, fifo_enable_c, col, row, window_valid, win_col, win_row,
    input  busy, frame_done
`ifdef SOBEL_CTRL_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  start, pixel_valid,
    output pixel_ready, fifo_enable_c, col, row, window_valid, win_col, win_row,
    output busy, frame_done
`ifdef SOBEL_CTRL_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel line-buffer datapath: pixel acceptance, raster position, window-valid flags.
// Optional idle timeout enabled by defining SOBEL_CTRL_TIMEOUT_EN.
module sobel_window_ctrl #(
  parameter int unsigned IMG_WIDTH      = 32,
  parameter int unsigned IMG_HEIGHT     = 32
`ifdef SOBEL_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic               clk,
  input logic               rst,
  sobel_window_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
`ifdef SOBEL_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          win_valid_q, win_valid_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;
`ifdef SOBEL_CTRL_TIMEOUT_EN
  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`endif

  assign accept = bus.pixel_valid & ready_q;

  // Next-state, counter and window computation
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = 1'b0;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
`ifdef SOBEL_CTRL_TIMEOUT_EN
    idle_d      = idle_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FILL;
          row_d   = '0;
          col_d   = '0;
`ifdef SOBEL_CTRL_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      S_FILL, S_RUN: begin
        if (accept) begin
`ifdef SOBEL_CTRL_TIMEOUT_EN
          idle_d = '0;
`endif
          // Window centre lags the incoming pixel by one row and one column
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - RW'(1);
            win_col_d   = col_q - CW'(1);
          end
          if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_HEIGHT - 1)) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
              if (row_q == RW'(1)) state_d = S_RUN;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
`ifdef SOBEL_CTRL_TIMEOUT_EN
        else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          row_d     = '0;
          col_d     = '0;
          idle_d    = '0;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_FILL) || (state_d == S_RUN);
    busy_d  = ready_d;
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SOBEL_CTRL_TIMEOUT_EN
      idle_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SOBEL_CTRL_TIMEOUT_EN
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.pixel_ready   = ready_q;
  assign bus.fifo_enable_c = accept;
  assign bus.col           = col_q;
  assign bus.row           = row_q;
  assign bus.window_valid  = win_valid_q;
  assign bus.win_col       = win_col_q;
  assign bus.win_row       = win_row_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
`ifdef SOBEL_CTRL_TIMEOUT_EN
  assign bus.timeout       = timeout_q;
`endif
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: random stimulus against a pixel-index frame model.
// Timeout checks are compiled in when SOBEL_CTRL_TIMEOUT_EN is defined.
module tb_sobel_window_ctrl;
  localparam int W = 32;
  localparam int H = 32;
`ifdef SOBEL_CTRL_TIMEOUT_EN
  localparam int TO = 255;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sobel_window_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame position as a linear pixel index
  bit m_active, m_done, m_wv, m_to;
  int m_k, m_wr, m_wc, m_idle;
  int win_cnt, last_wr, last_wc, to_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_wv = 0; m_to = 0;
    m_k = 0; m_wr = 0; m_wc = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit s, input bit pv, input bit r);
    int rr, cc;
    if (r) begin
      model_reset();
      return;
    end
    m_wv = 0;
    m_to = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_active && pv) begin
      rr = m_k / W;
      cc = m_k % W;
      if (rr >= 2 && cc >= 2) begin
        m_wv = 1; m_wr = rr - 1; m_wc = cc - 1;
      end
      m_idle = 0;
      m_k++;
      if (m_k == W * H) begin
        m_k = 0; m_active = 0; m_done = 1;
      end
    end else if (m_active) begin
`ifdef SOBEL_CTRL_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_active = 0; m_k = 0; m_idle = 0; m_to = 1;
      end
`endif
    end else if (s) begin
      m_active = 1; m_k = 0; m_idle = 0;
    end
  endtask

  task automatic check_outputs();
    check("pixel_ready", bus.pixel_ready, m_active);
    check("busy", bus.busy, m_active);
    check("frame_done", bus.frame_done, m_done);
    check("row", bus.row, m_k / W);
    check("col", bus.col, m_k % W);
    check("window_valid", bus.window_valid, m_wv);
    check("win_row", bus.win_row, m_wr);
    check("win_col", bus.win_col, m_wc);
`ifdef SOBEL_CTRL_TIMEOUT_EN
    check("timeout", bus.timeout, m_to);
`endif
  endtask

  // One clock: drive, check combinational enable, clock, check registered outputs and frame totals
  task automatic cyc(input bit s, input bit pv, input bit r);
    bus.start = s;
    bus.pixel_valid = pv;
    rst = r;
    #1;
    check("fifo_enable", bus.fifo_enable_c, m_active & pv);
    @(posedge clk);
    model_step(s, pv, r);
    #1;
    check_outputs();
    if (r) begin
      win_cnt = 0;
    end else begin
      if (bus.window_valid) begin
        win_cnt++;
        last_wr = bus.win_row;
        last_wc = bus.win_col;
        if (win_cnt == 1) begin
          check("first_win_row", bus.win_row, 1);
          check("first_win_col", bus.win_col, 1);
        end
      end
      if (bus.frame_done) begin
        check("win_count", win_cnt, (H - 2) * (W - 2));
        check("last_win_row", last_wr, H - 2);
        check("last_win_col", last_wc, W - 2);
        win_cnt = 0;
      end
`ifdef SOBEL_CTRL_TIMEOUT_EN
      if (bus.timeout) begin
        to_cnt++;
        win_cnt = 0;
      end
`endif
    end
  endtask

  task automatic run_frame(input int gap_pct);
    bit fd = 0;
    bit s, pv;
    for (int i = 0; i < 4000 && !fd; i++) begin
      pv = ($urandom_range(0, 99) >= gap_pct);
      s  = (m_active && m_k == 10 * W + 7) || ($urandom_range(0, 99) < 3);
      cyc(s, pv, 0);
      fd = bus.frame_done;
    end
    check("frame_completed", fd, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pixel_valid = 1'b0;
    model_reset();
    win_cnt = 0; last_wr = 0; last_wc = 0; to_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();

    // Pixels offered while idle must not be taken
    repeat (4) cyc(0, 1, 0);

    // Continuous frame; Start arrives together with a pixel
    cyc(1, 1, 0);
    run_frame(0);

    // Start during DONE is dropped, the following one launches a back-to-back frame
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    run_frame(0);

    // Gapped frame with spurious starts
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    run_frame(40);

    // Reset held two cycles in the middle of RUN
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    for (int i = 0; i < 2000 && m_k < 5 * W + 3; i++) cyc(0, 1'($urandom_range(0, 1)), 0);
    check("reached_row5", m_k >= 5 * W + 3, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    repeat (4) cyc(0, 1, 0);

    // Starved frame: pixels stop at row 3
    cyc(1, 1, 0);
    for (int i = 0; i < 2000 && m_k < 3 * W + 5; i++) cyc(0, 1, 0);
    repeat (300) cyc(0, 0, 0);
`ifdef SOBEL_CTRL_TIMEOUT_EN
    check("timeout_pulses", to_cnt, 1);
    check("busy_after_timeout", bus.busy, 0);
`else
    check("busy_while_starved", bus.busy, 1);
`endif
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Frame sequencer for the Sobel line-buffer datapath.
- Accepts a raster pixel stream and drives the shared shift-enable of the two 32-cell line-buffer FIFOs and the 3x3 window registers.
- Tracks row and column position and flags cycles where the 3x3 window holds a complete, valid neighbourhood for the Sobel kernel.
- Carries no pixel data: control only.

Parameters:
- IMG_WIDTH, 32: pixels per line; must equal the line-buffer depth.
- IMG_HEIGHT, 32: lines per frame, minimum 3.
- TIMEOUT_CYCLES, 255: idle-cycle limit; used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- PixelValid  in  1  upstream presents a pixel this cycle.
- PixelReady  out  1  controller accepts a pixel this cycle.
- FifoEnable  out  1  shift enable to the line buffers and window registers.
- Col  out  $clog2(IMG_WIDTH)  column of the next pixel to be accepted.
- Row  out  $clog2(IMG_HEIGHT)  row of the next pixel to be accepted.
- WindowValid  out  1  the window centred at (WinRow, WinCol) is complete.
- WinCol  out  $clog2(IMG_WIDTH)  centre column of the current window.
- WinRow  out  $clog2(IMG_HEIGHT)  centre row of the current window.
- Busy  out  1  high in FILL or RUN.
- FrameDone  out  1  one-cycle pulse at the end of a frame.
- Timeout  out  1  present only with SOBEL_CTRL_TIMEOUT_EN.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high: a Reset sampled high at a CLK edge forces state IDLE and zeroes all outputs and counters.
- Reset takes priority over every other input, including mid-frame. No FrameDone is generated on reset.
- A frame aborted by reset needs a new Start.
- States:
  - IDLE: PixelReady=0. Start=1 -> FILL, with Row=0 and Col=0.
  - FILL: PixelReady=1. Active while Row<2 (priming the two line buffers).
  - RUN: PixelReady=1. Active while Row>=2.
  - DONE: lasts one cycle. FrameDone=1, PixelReady=0. Always -> IDLE.
- Acceptance: accept = PixelValid & PixelReady.
  - FifoEnable = accept (combinational).
  - With no accept, all counters hold and the datapath is frozen.
- Counter update on accept:
  - Col=IMG_WIDTH-1 wraps Col to 0 and increments Row; otherwise Col increments.
  - Accept at Row=1, Col=IMG_WIDTH-1 -> RUN.
  - Accept at Row=IMG_HEIGHT-1, Col=IMG_WIDTH-1 -> DONE; Row and Col return to 0.
- Window output (registered, latency 1):
  - WindowValid=1 in the cycle after an accept of a pixel with Row>=2 and Col>=2; otherwise 0.
  - WinRow=Row-1 and WinCol=Col-1, captured from that accept.
  - WinRow/WinCol hold their last value when WindowValid=0.
  - Border centres (row 0, row H-1, col 0, col W-1) are never flagged.
  - Per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows, no duplicates, raster order.
- Busy=1 in FILL and RUN, 0 in IDLE and DONE.
- Start while Busy or in DONE is ignored: no counter effect, no restart.
- Start and PixelValid arriving in the same IDLE cycle: the pixel is not accepted (PixelReady=0 in IDLE).
- Last accept and a new Start in the same cycle: the Start is ignored.
- PixelValid while in IDLE or DONE is not accepted and produces no FifoEnable.

Optional Feature:
- Macro SOBEL_CTRL_TIMEOUT_EN, defined:
  - Adds the Timeout port and an idle counter of $clog2(TIMEOUT_CYCLES+1) bits.
  - The counter clears on every accept and on entering FILL. It increments on every FILL/RUN cycle with no accept.
  - When it reaches TIMEOUT_CYCLES: Timeout=1 for one cycle, -> IDLE, Row and Col cleared, no FrameDone.
- Macro undefined:
  - No Timeout port and no counter.
  - The controller waits indefinitely for PixelValid.

Test Plan:
- Reset: hold Reset 2 cycles mid-RUN (e.g. Row=5) -> next cycle all outputs 0, state IDLE; PixelValid=1 gives FifoEnable=0 until Start.
- Continuous frame: Start, then PixelValid=1 for 1024 cycles (32x32) -> 1024 FifoEnable pulses.
  - First WindowValid one cycle after the 67th accept (Row=2, Col=2), with WinRow=1, WinCol=1.
  - Exactly 900 WindowValid pulses, last with WinRow=30, WinCol=30.
  - FrameDone one cycle after the 1024th accept.
- Gapped stream: PixelValid toggling pseudo-randomly -> FifoEnable equals PixelValid while Busy. Window sequence identical to the continuous case; Row and Col hold during gaps.
- Spurious Start: pulse Start at Row=10, Col=7 -> counters unchanged, frame completes normally; a single FrameDone.
- Back-to-back frames: Start in the cycle after FrameDone -> second frame starts at Row=0, Col=0; 900 windows again.
- Timeout (macro defined, TIMEOUT_CYCLES=255): stop PixelValid at Row=3 -> Timeout pulses after exactly 255 idle cycles, Busy=0, no FrameDone. With the macro undefined, Busy stays 1 indefinitely.
